// File: rtl/wb_trace_checker.sv
// Writeback trace checker: queues CPU register writes and compares them
// in order against a golden reference stream.
module wb_trace_checker #(
  parameter int          DEPTH  = 16,
  parameter logic [31:0] END_PC = 32'hbfc00100
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_wen,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  input  logic                     ref_valid,
  output logic                     ref_ready,
  input  logic [31:0]              ref_pc,
  input  logic [4:0]               ref_wnum,
  input  logic [31:0]              ref_wdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [31:0]              rec_cnt,
  output logic                     err,
  output logic                     overflow,
  output logic [31:0]              err_pc,
  output logic [31:0]              err_got,
  output logic [31:0]              err_exp,
  output logic                     pass
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_FAIL, S_DONE} state_t;

  state_t        state;
  logic          end_seen;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic [31:0] m_pc    [DEPTH];
  logic [3:0]  m_wen   [DEPTH];
  logic [4:0]  m_wnum  [DEPTH];
  logic [31:0] m_wdata [DEPTH];

  logic        push_req;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] mask;
  logic        match;

  assign push_req = |debug_wb_rf_wen && (debug_wb_rf_wnum != 5'd0);
  assign full     = (fifo_level == (AW+1)'(DEPTH));
  assign empty    = (fifo_level == '0);
  assign ref_ready = (state == S_RUN) && !empty;
  assign pop      = ref_valid && ref_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign mask = {{8{m_wen[rptr][3]}}, {8{m_wen[rptr][2]}},
                 {8{m_wen[rptr][1]}}, {8{m_wen[rptr][0]}}};

  assign match = (m_pc[rptr] == ref_pc) &&
                 (m_wnum[rptr] == ref_wnum) &&
                 ((m_wdata[rptr] & mask) == (ref_wdata & mask));

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      m_pc[wptr]    <= debug_wb_pc;
      m_wen[wptr]   <= debug_wb_rf_wen;
      m_wnum[wptr]  <= debug_wb_rf_wnum;
      m_wdata[wptr] <= debug_wb_rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_RUN;
      end_seen   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      rec_cnt    <= '0;
      err        <= 1'b0;
      overflow   <= 1'b0;
      err_pc     <= '0;
      err_got    <= '0;
      err_exp    <= '0;
      pass       <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) begin
        overflow <= 1'b1;
        err      <= 1'b1;
      end
      if (pop && match && rec_cnt != '1)
        rec_cnt <= rec_cnt + 32'd1;
      unique case (state)
        S_RUN: begin
          if (debug_wb_pc == END_PC) end_seen <= 1'b1;
          if (pop && !match) begin
            state   <= S_FAIL;
            err     <= 1'b1;
            err_pc  <= m_pc[rptr];
            err_got <= m_wdata[rptr];
            err_exp <= ref_wdata;
          end else if (drop) begin
            state <= S_FAIL;
          end else if (end_seen && empty && !err) begin
            state <= S_DONE;
            pass  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: vector table plus corner sequences.
module tb_wb_trace_checker;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] END_PC = 32'hbfc00100;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        ref_valid;
  logic        ref_ready;
  logic [31:0] ref_pc;
  logic [4:0]  ref_wnum;
  logic [31:0] ref_wdata;
  logic [2:0]  fifo_level;
  logic [31:0] rec_cnt;
  logic        err;
  logic        overflow;
  logic [31:0] err_pc;
  logic [31:0] err_got;
  logic [31:0] err_exp;
  logic        pass;

  int checks = 0;
  int errors = 0;

  wb_trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk(clk),
    .resetn(resetn),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ref_valid(ref_valid),
    .ref_ready(ref_ready),
    .ref_pc(ref_pc),
    .ref_wnum(ref_wnum),
    .ref_wdata(ref_wdata),
    .fifo_level(fifo_level),
    .rec_cnt(rec_cnt),
    .err(err),
    .overflow(overflow),
    .err_pc(err_pc),
    .err_got(err_got),
    .err_exp(err_exp),
    .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
    logic [4:0]  rwnum;
    logic [31:0] rwdata;
    logic [2:0]  lvl;
    logic [31:0] cnt;
    logic        err;
    logic        ovf;
    logic        pass;
    logic        rdy;
    logic [31:0] epc;
    logic [31:0] egot;
    logic [31:0] eexp;
  } vec_t;

  vec_t tbl [14];
  vec_t v;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    resetn            = t.rstn;
    debug_wb_pc       = t.pc;
    debug_wb_rf_wen   = t.wen;
    debug_wb_rf_wnum  = t.wnum;
    debug_wb_rf_wdata = t.wdata;
    ref_valid         = t.rv;
    ref_pc            = t.rpc;
    ref_wnum          = t.rwnum;
    ref_wdata         = t.rwdata;
    @(posedge clk);
    #1;
    chk({tag, ".lvl"},  32'(fifo_level), 32'(t.lvl));
    chk({tag, ".cnt"},  rec_cnt,         t.cnt);
    chk({tag, ".err"},  32'(err),        32'(t.err));
    chk({tag, ".ovf"},  32'(overflow),   32'(t.ovf));
    chk({tag, ".pass"}, 32'(pass),       32'(t.pass));
    chk({tag, ".rdy"},  32'(ref_ready),  32'(t.rdy));
    chk({tag, ".epc"},  err_pc,          t.epc);
    chk({tag, ".egot"}, err_got,         t.egot);
    chk({tag, ".eexp"}, err_exp,         t.eexp);
  endtask

  initial begin
    resetn = 1'b0;
    debug_wb_pc = '0;
    debug_wb_rf_wen = '0;
    debug_wb_rf_wnum = '0;
    debug_wb_rf_wdata = '0;
    ref_valid = 1'b0;
    ref_pc = '0;
    ref_wnum = '0;
    ref_wdata = '0;

    tbl[0]  = '{1'b0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0,
                3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = tbl[0];
    // three matching records with ref_valid held high
    tbl[2]  = '{1'b1, 32'h1000, 4'hf, 5'd1, 32'h11111111,
                1'b1, 32'h1000, 5'd1, 32'h11111111,
                3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{1'b1, 32'h1004, 4'hf, 5'd2, 32'h22222222,
                1'b1, 32'h1000, 5'd1, 32'h11111111,
                3'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 32'h1008, 4'hf, 5'd3, 32'h33333333,
                1'b1, 32'h1004, 5'd2, 32'h22222222,
                3'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 32'h100c, 4'h0, 5'd0, 32'h0,
                1'b1, 32'h1008, 5'd3, 32'h33333333,
                3'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    // non-qualifying writes
    tbl[6]  = '{1'b1, 32'h1010, 4'hf, 5'd0, 32'hffffffff,
                1'b0, 32'h0, 5'd0, 32'h0,
                3'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, 32'h1014, 4'h0, 5'd5, 32'hffffffff,
                1'b0, 32'h0, 5'd0, 32'h0,
                3'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    // partial byte enables mask the upper half
    tbl[8]  = '{1'b1, 32'h1018, 4'b0011, 5'd4, 32'hdead1234,
                1'b0, 32'h0, 5'd0, 32'h0,
                3'd1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 32'h101c, 4'h0, 5'd0, 32'h0,
                1'b1, 32'h1018, 5'd4, 32'h00001234,
                3'd0, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    // data mismatch
    tbl[10] = '{1'b1, 32'hbfc00020, 4'hf, 5'd7, 32'h12345678,
                1'b0, 32'h0, 5'd0, 32'h0,
                3'd1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 32'h1020, 4'h0, 5'd0, 32'h0,
                1'b1, 32'hbfc00020, 5'd7, 32'h12345679,
                3'd0, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0,
                32'hbfc00020, 32'h12345678, 32'h12345679};
    tbl[12] = '{1'b1, 32'h1024, 4'hf, 5'd1, 32'h1,
                1'b1, 32'h1024, 5'd1, 32'h1,
                3'd1, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0,
                32'hbfc00020, 32'h12345678, 32'h12345679};
    tbl[13] = tbl[0];

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("v%0d", i));

    // overflow: five captures into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      v = '{1'b1, 32'h3000 + 32'(i * 4), 4'hf, 5'(i + 1), 32'(i),
            1'b0, 32'h0, 5'd0, 32'h0,
            (i < 4) ? 3'(i + 1) : 3'd4, 32'd0, (i == 4), (i == 4), 1'b0,
            (i < 4), 32'h0, 32'h0, 32'h0};
      apply(v, $sformatf("ovf%0d", i));
    end
    apply(tbl[0], "ovf_rst");

    // push and pop together while full: no overflow
    for (int i = 0; i < 4; i++) begin
      v = '{1'b1, 32'h4000 + 32'(i * 4), 4'hf, 5'd9, 32'(i),
            1'b0, 32'h0, 5'd0, 32'h0,
            3'(i + 1), 32'd0, 1'b0, 1'b0, 1'b0, 1'b1,
            32'h0, 32'h0, 32'h0};
      apply(v, $sformatf("fill%0d", i));
    end
    v = '{1'b1, 32'h4010, 4'hf, 5'd9, 32'h4,
          1'b1, 32'h4000, 5'd9, 32'h0,
          3'd4, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    apply(v, "fullpp");
    apply(tbl[0], "fp_rst");

    // end of test with two records still queued
    v = '{1'b1, 32'h2000, 4'hf, 5'd1, 32'haa,
          1'b0, 32'h0, 5'd0, 32'h0,
          3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    apply(v, "end_c1");
    v = '{1'b1, 32'h2004, 4'hf, 5'd2, 32'hbb,
          1'b0, 32'h0, 5'd0, 32'h0,
          3'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    apply(v, "end_c2");
    v = '{1'b1, END_PC, 4'h0, 5'd0, 32'h0,
          1'b0, 32'h0, 5'd0, 32'h0,
          3'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    apply(v, "end_pc");
    v = '{1'b1, 32'h2008, 4'h0, 5'd0, 32'h0,
          1'b1, 32'h2000, 5'd1, 32'haa,
          3'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    apply(v, "end_p1");
    v = '{1'b1, 32'h200c, 4'h0, 5'd0, 32'h0,
          1'b1, 32'h2004, 5'd2, 32'hbb,
          3'd0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    apply(v, "end_p2");
    v = '{1'b1, 32'h2010, 4'h0, 5'd0, 32'h0,
          1'b0, 32'h0, 5'd0, 32'h0,
          3'd0, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
    apply(v, "end_pass");
    apply(tbl[0], "end_rst");

    // mismatch in the same cycle END_PC appears: no pass
    v = '{1'b1, 32'h5000, 4'hf, 5'd3, 32'h77,
          1'b0, 32'h0, 5'd0, 32'h0,
          3'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    apply(v, "mx_c");
    v = '{1'b1, END_PC, 4'h0, 5'd0, 32'h0,
          1'b1, 32'h5000, 5'd3, 32'h78,
          3'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0,
          32'h5000, 32'h77, 32'h78};
    apply(v, "mx_end");
    v = '{1'b1, 32'h5004, 4'h0, 5'd0, 32'h0,
          1'b0, 32'h0, 5'd0, 32'h0,
          3'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0,
          32'h5000, 32'h77, 32'h78};
    apply(v, "mx_idle1");
    apply(v, "mx_idle2");
    apply(tbl[0], "mx_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
